// File: rtl/snoop_responder_pkg.sv
// Shared MSI bus types plus helpers for the snoop responder.
package snoop_responder_pkg;

  typedef enum logic [3:0] {
    NOOP              = 4'd0,
    READ_MISS_0       = 4'd1,
    READ_MISS_1       = 4'd2,
    WRITE_MISS_0      = 4'd3,
    WRITE_MISS_1      = 4'd4,
    INVALIDATE_0      = 4'd5,
    INVALIDATE_1      = 4'd6,
    READ_MISS_0_WAIT  = 4'd7,
    READ_MISS_1_WAIT  = 4'd8,
    WRITE_MISS_0_WAIT = 4'd9,
    WRITE_MISS_1_WAIT = 4'd10,
    INVALIDATE_0_WAIT = 4'd11,
    INVALIDATE_1_WAIT = 4'd12
  } bus_op_t;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    SHARED   = 2'd1,
    MODIFIED = 2'd2
  } blk_state_t;

  typedef enum logic [2:0] {
    SNP_IDLE    = 3'd0,
    SNP_LOOKUP  = 3'd1,
    SNP_FLUSH   = 3'd2,
    SNP_UPDATE  = 3'd3,
    SNP_ACK     = 3'd4,
    SNP_RELEASE = 3'd5
  } snp_state_t;

  // Kind of request, independent of which core issued it.
  typedef enum logic [1:0] {
    OPC_NONE  = 2'd0,
    OPC_READ  = 2'd1,
    OPC_WRITE = 2'd2,
    OPC_INVAL = 2'd3
  } op_class_t;

  // True when op is a request (not a *_WAIT) issued by the core other than core_id.
  function automatic logic other_core_op(bus_op_t op, int core_id);
    logic r;
    case (op)
      READ_MISS_0, WRITE_MISS_0, INVALIDATE_0: r = (core_id != 0);
      READ_MISS_1, WRITE_MISS_1, INVALIDATE_1: r = (core_id == 0);
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

  // The *_WAIT code the requester holds while waiting on op; NOOP for anything else.
  function automatic bus_op_t wait_of(bus_op_t op);
    bus_op_t r;
    case (op)
      READ_MISS_0:  r = READ_MISS_0_WAIT;
      READ_MISS_1:  r = READ_MISS_1_WAIT;
      WRITE_MISS_0: r = WRITE_MISS_0_WAIT;
      WRITE_MISS_1: r = WRITE_MISS_1_WAIT;
      INVALIDATE_0: r = INVALIDATE_0_WAIT;
      INVALIDATE_1: r = INVALIDATE_1_WAIT;
      default:      r = NOOP;
    endcase
    return r;
  endfunction

  function automatic op_class_t op_class(bus_op_t op);
    op_class_t r;
    case (op)
      READ_MISS_0, READ_MISS_1:   r = OPC_READ;
      WRITE_MISS_0, WRITE_MISS_1: r = OPC_WRITE;
      INVALIDATE_0, INVALIDATE_1: r = OPC_INVAL;
      default:                    r = OPC_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snoop_responder.sv
// Snoop responder: watches the shared bus for the other core's requests, looks up
// the local line, writes back MODIFIED data, downgrades/invalidates, then acks.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | watching bus for the other core's request
// LOOKUP      | tag/state/data returned from the arrays, decide the action
// FLUSH       | write-back of MODIFIED block, held until mem_wr_ack
// UPDATE      | one-cycle line state write
// ACK         | one-cycle snp_ack pulse to the requester
// RELEASE     | wait for the requester to drop its *_WAIT code
module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int CORE_ID = 0,
  parameter int IDX_W   = 6,
  parameter int OFF_W   = 2,
  parameter int BLK_W   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  bus_op_t                   bus_op,
  input  logic [15:0]               bus_addr,
  output logic                      snp_ack,
  output logic                      snp_busy,
  output logic                      snp_err,
  output logic [IDX_W-1:0]          tag_rd_idx,
  input  logic [16-IDX_W-OFF_W-1:0] tag_rd_tag,
  input  blk_state_t                tag_rd_state,
  input  logic [BLK_W-1:0]          data_rd_blk,
  output logic                      st_wr_en,
  output logic [IDX_W-1:0]          st_wr_idx,
  output blk_state_t                st_wr_state,
  output logic                      mem_wr_en,
  output logic [15:0]               mem_wr_addr,
  output logic [BLK_W-1:0]          mem_wr_data,
  input  logic                      mem_wr_ack
);

  localparam int BLKA_W = 16 - OFF_W;

  localparam logic [2:0] ST_IDLE    = SNP_IDLE;
  localparam logic [2:0] ST_LOOKUP  = SNP_LOOKUP;
  localparam logic [2:0] ST_FLUSH   = SNP_FLUSH;
  localparam logic [2:0] ST_UPDATE  = SNP_UPDATE;
  localparam logic [2:0] ST_ACK     = SNP_ACK;
  localparam logic [2:0] ST_RELEASE = SNP_RELEASE;

  logic [2:0]        state;
  bus_op_t           op_q;
  logic [BLKA_W-1:0] blk_addr_q;
  blk_state_t        new_state_q;
  logic [15:0]       mem_wr_addr_q;
  logic [BLK_W-1:0]  mem_wr_data_q;
  logic              snp_err_q;

  logic              trigger;
  logic              hit;
  logic [2:0]        lk_next;
  blk_state_t        lk_state;
  logic              lk_flush;
  logic              lk_err;

  // Word offset is irrelevant to a block-granular snoop.
  logic              unused_off;
  assign unused_off = ^bus_addr[OFF_W-1:0];

  // Reset gates the trigger so the lookup index reads zero while in reset.
  assign trigger = !rst && (state == ST_IDLE) && other_core_op(bus_op, CORE_ID);

  // Index goes straight from the bus on the trigger cycle so the arrays answer in LOOKUP.
  assign tag_rd_idx = (state == ST_IDLE) ? (trigger ? bus_addr[OFF_W +: IDX_W] : '0)
                                         : blk_addr_q[IDX_W-1:0];

  assign hit = (tag_rd_tag == blk_addr_q[BLKA_W-1:IDX_W]) && (tag_rd_state != INVALID);

  // LOOKUP decision: next FSM state, line state to write, and whether to flush.
  always_comb begin
    lk_next  = ST_ACK;
    lk_state = INVALID;
    lk_flush = 1'b0;
    lk_err   = 1'b0;
    if (hit) begin
      case (op_class(op_q))
        OPC_READ: begin
          lk_state = SHARED;
          if (tag_rd_state == MODIFIED) begin
            lk_next  = ST_FLUSH;
            lk_flush = 1'b1;
          end
        end
        OPC_WRITE: begin
          lk_state = INVALID;
          if (tag_rd_state == MODIFIED) begin
            lk_next  = ST_FLUSH;
            lk_flush = 1'b1;
          end else begin
            lk_next = ST_UPDATE;
          end
        end
        OPC_INVAL: begin
          // Invalidate of a dirty remote copy is illegal in MSI: drop the line, flag it.
          lk_state = INVALID;
          lk_next  = ST_UPDATE;
          lk_err   = (tag_rd_state == MODIFIED);
        end
        default: lk_next = ST_ACK;
      endcase
    end
  end

  // Snoop FSM with latch registers for the op, address and write-back payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      op_q          <= NOOP;
      blk_addr_q    <= '0;
      new_state_q   <= INVALID;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      snp_err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            op_q       <= bus_op;
            blk_addr_q <= bus_addr[15:OFF_W];
            state      <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          new_state_q <= lk_state;
          if (lk_flush) begin
            mem_wr_addr_q <= {blk_addr_q, {OFF_W{1'b0}}};
            mem_wr_data_q <= data_rd_blk;
          end
          if (lk_err) snp_err_q <= 1'b1;
          state <= lk_next;
        end
        ST_FLUSH: begin
          if (mem_wr_ack) state <= ST_UPDATE;
        end
        ST_UPDATE:  state <= ST_ACK;
        ST_ACK:     state <= ST_RELEASE;
        ST_RELEASE: begin
          if (bus_op != wait_of(op_q)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign snp_ack     = (state == ST_ACK);
  assign snp_busy    = (state == ST_LOOKUP) || (state == ST_FLUSH) || (state == ST_UPDATE);
  assign snp_err     = snp_err_q;
  assign st_wr_en    = (state == ST_UPDATE);
  assign st_wr_idx   = blk_addr_q[IDX_W-1:0];
  assign st_wr_state = new_state_q;
  assign mem_wr_en   = (state == ST_FLUSH);
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule
